// File: rtl/axi_w_burst_router.sv
// W-channel router: replays AW routing decisions in order and steers each W burst to one master port
// or sinks it. Also flags WLAST/AWLEN disagreement and reports the outstanding burst count.
module axi_w_burst_router #(
    parameter int N_INIT_PORT = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int LEN_W       = 8,
    parameter bit CHECK_LEN   = 1'b1,
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   aw_push_i,
    output logic                   aw_ready_o,
    input  logic [N_INIT_PORT-1:0] aw_dest_i,
    input  logic                   aw_err_i,
    input  logic [LEN_W-1:0]       aw_len_i,
    input  logic                   wvalid_i,
    input  logic                   wlast_i,
    output logic                   wready_o,
    output logic [N_INIT_PORT-1:0] wvalid_o,
    input  logic [N_INIT_PORT-1:0] wready_i,
    output logic                   err_done_o,
    output logic                   last_mismatch_o,
    output logic [CNT_W-1:0]       outstanding_o
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                   err;
        logic [LEN_W-1:0]       len;
        logic [N_INIT_PORT-1:0] dest;
    } route_t;

    typedef enum logic [1:0] {IDLE, FWD, SINK} state_t;

    route_t                   mem [FIFO_DEPTH];
    route_t                   head;
    route_t                   entry_in;
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [FCNT_W-1:0]        fcnt;
    logic                     fifo_empty, fifo_full, push, pop;
    state_t                   state, state_d;
    logic [N_INIT_PORT-1:0]   cur_dest;
    logic [LEN_W-1:0]         cur_len;
    logic [LEN_W-1:0]         bcnt;
    logic                     wready_c, beat, burst_end;
    logic [N_INIT_PORT-1:0]   wvalid_c;

    assign fifo_empty = (fcnt == '0);
    assign fifo_full  = (fcnt == FCNT_W'(FIFO_DEPTH));
    assign push       = aw_push_i & ~fifo_full;
    assign head       = mem[rd_ptr];

    // A route with no destination bit set can only be sunk.
    assign entry_in.err  = aw_err_i | (aw_dest_i == '0);
    assign entry_in.len  = aw_len_i;
    assign entry_in.dest = aw_dest_i;

    always_comb begin
        state_d   = state;
        pop       = 1'b0;
        wready_c  = 1'b0;
        wvalid_c  = '0;
        beat      = 1'b0;
        burst_end = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = head.err ? SINK : FWD;
                end
            end
            FWD: begin
                wvalid_c = {N_INIT_PORT{wvalid_i}} & cur_dest;
                wready_c = |(wready_i & cur_dest);
            end
            SINK:    wready_c = 1'b1;
            default: state_d  = IDLE;
        endcase
        beat = wvalid_i & wready_c;
        // Back-to-back bursts: the next head is loaded on the WLAST beat itself.
        if (state != IDLE && beat && wlast_i) begin
            burst_end = 1'b1;
            if (!fifo_empty) begin
                pop     = 1'b1;
                state_d = head.err ? SINK : FWD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    assign wready_o        = wready_c;
    assign wvalid_o        = wvalid_c;
    assign aw_ready_o      = ~fifo_full;
    assign err_done_o      = burst_end && (state == SINK);
    assign last_mismatch_o = CHECK_LEN && burst_end && (bcnt != cur_len);
    assign outstanding_o   = CNT_W'(fcnt) + CNT_W'(state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
            bcnt   <= '0;
        end else begin
            state <= state_d;
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fcnt <= fcnt + FCNT_W'(1);
                2'b01:   fcnt <= fcnt - FCNT_W'(1);
                default: fcnt <= fcnt;
            endcase
            if (pop)
                bcnt <= '0;
            else if (beat && bcnt != '1)
                bcnt <= bcnt + LEN_W'(1);
        end
    end

    // Route storage and the active route carry no reset; state/fcnt qualify them.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= entry_in;
        if (pop) begin
            cur_dest <= head.dest;
            cur_len  <= head.len;
        end
    end

endmodule

// File: tb/tb_axi_w_burst_router.sv
// Directed bench for axi_w_burst_router; a CHECK_LEN=0 twin shares all inputs.
module tb_axi_w_burst_router;

    localparam int N   = 4;
    localparam int FD  = 8;
    localparam int LW  = 8;
    localparam int CW  = $clog2(FD + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          aw_push, aw_err;
    logic [N-1:0]  aw_dest;
    logic [LW-1:0] aw_len;
    logic          wvalid, wlast;
    logic [N-1:0]  wready_in;

    logic          aw_ready, wready, err_done, mism;
    logic [N-1:0]  wvalid_out;
    logic [CW-1:0] outst;
    logic          aw_ready_nc, wready_nc, err_done_nc, mism_nc;
    logic [N-1:0]  wvalid_out_nc;
    logic [CW-1:0] outst_nc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_w_burst_router #(.N_INIT_PORT(N), .FIFO_DEPTH(FD), .LEN_W(LW), .CHECK_LEN(1'b1)) dut (
        .clk(clk), .rst(rst), .aw_push_i(aw_push), .aw_ready_o(aw_ready), .aw_dest_i(aw_dest),
        .aw_err_i(aw_err), .aw_len_i(aw_len), .wvalid_i(wvalid), .wlast_i(wlast), .wready_o(wready),
        .wvalid_o(wvalid_out), .wready_i(wready_in), .err_done_o(err_done),
        .last_mismatch_o(mism), .outstanding_o(outst)
    );

    axi_w_burst_router #(.N_INIT_PORT(N), .FIFO_DEPTH(FD), .LEN_W(LW), .CHECK_LEN(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .aw_push_i(aw_push), .aw_ready_o(aw_ready_nc), .aw_dest_i(aw_dest),
        .aw_err_i(aw_err), .aw_len_i(aw_len), .wvalid_i(wvalid), .wlast_i(wlast), .wready_o(wready_nc),
        .wvalid_o(wvalid_out_nc), .wready_i(wready_in), .err_done_o(err_done_nc),
        .last_mismatch_o(mism_nc), .outstanding_o(outst_nc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_aw(input logic p, input logic e, input logic [N-1:0] d, input logic [LW-1:0] l);
        aw_push = p;
        aw_err  = e;
        aw_dest = d;
        aw_len  = l;
    endtask

    initial begin
        rst = 1'b1;
        set_aw(1'b0, 1'b0, '0, '0);
        wvalid = 1'b0; wlast = 1'b0; wready_in = '0;
        settle();
        chk("rst_wready", 32'(wready), 0);
        chk("rst_wvalid", 32'(wvalid_out), 0);
        chk("rst_outst", 32'(outst), 0);
        chk("rst_awready", 32'(aw_ready), 1);
        chk("rst_errdone", 32'(err_done), 0);
        chk("rst_mism", 32'(mism), 0);
        tick(); tick();
        rst = 1'b0;

        // 1: single 4-beat burst to port 2
        tick();
        set_aw(1'b1, 1'b0, 4'b0100, 8'd3);
        wready_in = 4'b0100;
        settle();
        chk("t1_awready", 32'(aw_ready), 1);
        tick();
        set_aw(1'b0, 1'b0, '0, '0);
        settle();
        chk("t1_outst_q", 32'(outst), 1);
        chk("t1_wvalid_idle", 32'(wvalid_out), 0);
        tick();
        wvalid = 1'b1;
        settle();
        chk("t1_outst_act", 32'(outst), 1);
        for (int i = 0; i < 4; i++) begin
            wlast = (i == 3);
            settle();
            chk("t1_wvalid", 32'(wvalid_out), 32'h4);
            chk("t1_wready", 32'(wready), 1);
            chk("t1_errdone", 32'(err_done), 0);
            chk("t1_mism", 32'(mism), 0);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        settle();
        chk("t1_outst_end", 32'(outst), 0);

        // 2: sunk 2-beat burst followed directly by a 1-beat burst to port 0
        set_aw(1'b1, 1'b1, 4'b0001, 8'd1);
        wready_in = 4'b0001;
        tick();
        set_aw(1'b1, 1'b0, 4'b0001, 8'd0);
        tick();
        set_aw(1'b0, 1'b0, '0, '0);
        wvalid = 1'b1; wlast = 1'b0;
        settle();
        chk("t2_outst", 32'(outst), 2);
        chk("t2_b1_wready", 32'(wready), 1);
        chk("t2_b1_wvalid", 32'(wvalid_out), 0);
        chk("t2_b1_errdone", 32'(err_done), 0);
        tick();
        wlast = 1'b1;
        settle();
        chk("t2_b2_wvalid", 32'(wvalid_out), 0);
        chk("t2_b2_errdone", 32'(err_done), 1);
        chk("t2_b2_mism", 32'(mism), 0);
        tick();
        settle();
        chk("t2_b3_wvalid", 32'(wvalid_out), 32'h1);
        chk("t2_b3_wready", 32'(wready), 1);
        chk("t2_b3_errdone", 32'(err_done), 0);
        chk("t2_b3_mism", 32'(mism), 0);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        settle();
        chk("t2_outst_end", 32'(outst), 0);

        // 3: fill the queue with no W traffic; one route is active, FD queued, extra push dropped
        wready_in = 4'b0010;
        for (int i = 0; i < FD + 2; i++) begin
            set_aw(1'b1, 1'b0, 4'b0010, 8'd0);
            settle();
            if (i == FD + 1) chk("t3_awready_full", 32'(aw_ready), 0);
            tick();
        end
        set_aw(1'b0, 1'b0, '0, '0);
        settle();
        chk("t3_outst_max", 32'(outst), FD + 1);
        chk("t3_awready", 32'(aw_ready), 0);
        wvalid = 1'b1; wlast = 1'b1;
        settle();
        chk("t3_wready", 32'(wready), 1);
        tick();
        settle();
        chk("t3_awready_after", 32'(aw_ready), 1);
        chk("t3_outst_after", 32'(outst), FD);
        for (int i = 0; i < FD; i++) tick();
        wvalid = 1'b0; wlast = 1'b0;
        settle();
        chk("t3_outst_drain", 32'(outst), 0);

        // 4: early WLAST on beat 2 of a 4-beat burst
        set_aw(1'b1, 1'b0, 4'b1000, 8'd3);
        wready_in = 4'b1000;
        tick();
        set_aw(1'b0, 1'b0, '0, '0);
        tick();
        wvalid = 1'b1; wlast = 1'b0;
        settle();
        chk("t4_b1_mism", 32'(mism), 0);
        tick();
        wlast = 1'b1;
        settle();
        chk("t4_b2_mism", 32'(mism), 1);
        chk("t4_b2_mism_nc", 32'(mism_nc), 0);
        tick();
        settle();
        chk("t4_idle_wready", 32'(wready), 0);
        chk("t4_idle_wvalid", 32'(wvalid_out), 0);
        chk("t4_outst", 32'(outst), 0);
        wvalid = 1'b0; wlast = 1'b0;

        // 5: backpressure for 5 cycles after the first beat
        set_aw(1'b1, 1'b0, 4'b0100, 8'd3);
        wready_in = 4'b0100;
        tick();
        set_aw(1'b0, 1'b0, '0, '0);
        tick();
        wvalid = 1'b1;
        tick();
        wready_in = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t5_stall_wvalid", 32'(wvalid_out), 32'h4);
            chk("t5_stall_wready", 32'(wready), 0);
            tick();
        end
        wready_in = 4'b0100;
        for (int i = 1; i < 4; i++) begin
            wlast = (i == 3);
            settle();
            chk("t5_wready", 32'(wready), 1);
            if (i == 3) chk("t5_last_mism", 32'(mism), 0);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        settle();
        chk("t5_outst", 32'(outst), 0);

        // 6: asynchronous reset mid-burst with three routes queued
        wready_in = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            set_aw(1'b1, 1'b0, 4'b0001, 8'd5);
            tick();
        end
        set_aw(1'b0, 1'b0, '0, '0);
        settle();
        chk("t6_outst_pre", 32'(outst), 4);
        wvalid = 1'b1;
        tick();
        settle();
        chk("t6_wvalid_pre", 32'(wvalid_out), 32'h1);
        rst = 1'b1;
        settle();
        chk("t6_rst_wvalid", 32'(wvalid_out), 0);
        chk("t6_rst_outst", 32'(outst), 0);
        chk("t6_rst_wready", 32'(wready), 0);
        chk("t6_rst_awready", 32'(aw_ready), 1);
        tick();
        rst = 1'b0;
        wvalid = 1'b0;
        tick();
        settle();
        chk("t6_post_outst", 32'(outst), 0);
        chk("t6_post_awready", 32'(aw_ready), 1);
        set_aw(1'b1, 1'b0, 4'b0010, 8'd0);
        wready_in = 4'b0010;
        tick();
        set_aw(1'b0, 1'b0, '0, '0);
        tick();
        wvalid = 1'b1; wlast = 1'b1;
        settle();
        chk("t6_new_wvalid", 32'(wvalid_out), 32'h2);
        chk("t6_new_wready", 32'(wready), 1);
        chk("t6_new_mism", 32'(mism), 0);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
        settle();
        chk("t6_new_outst", 32'(outst), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
